// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared state type and UART register constants for the TX path
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } txState_e;

  localparam logic [9:0] UART_DR_ADDR  = 10'h000;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [3:0] UART_BE_BYTE0 = 4'b0001;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          anyValid
);

  function automatic logic [IW-1:0] rotIdx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the far end so the entry closest to ptr is written last and wins.
  always_comb begin
    grant    = '0;
    anyValid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[rotIdx(ptr, i)]) grant = rotIdx(ptr, i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - line-granular round-robin sharing of the UART data register between byte producers
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter int         GAP_CYCLES   = 3,
  parameter int         LINE_TIMEOUT = 256,
  parameter logic [9:0] DR_ADDR      = UART_DR_ADDR
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [NUM_REQ-1:0]         REQ_VALID,
  input  logic [8*NUM_REQ-1:0]       REQ_DATA,
  output logic [NUM_REQ-1:0]         REQ_READY,
  output logic [9:0]                 UART_WRITE_ADDR,
  output logic [31:0]                UART_DATA_IN,
  output logic                       UART_WE,
  output logic [3:0]                 UART_BE,
  output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
  output logic                       BUSY
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (LINE_TIMEOUT > GAP_CYCLES + 1) ? LINE_TIMEOUT : GAP_CYCLES + 1;
  localparam int CW      = $clog2(CNT_MAX);

  txState_e      state, stateNext;
  logic [IW-1:0] owner, ownerNext, ptr, ptrNext, pick, ownerInc;
  logic [CW-1:0] cnt, cntNext;
  logic [7:0]    byteReg, byteNext;
  logic          anyValid, postWrite;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) uArb (
    .req      (REQ_VALID),
    .ptr      (ptr),
    .grant    (pick),
    .anyValid (anyValid)
  );

  assign ownerInc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      byteReg <= '0;
    end else begin
      state   <= stateNext;
      owner   <= ownerNext;
      ptr     <= ptrNext;
      cnt     <= cntNext;
      byteReg <= byteNext;
    end
  end

  // cnt is the idle counter in OWN and the pacing counter in GAP; each entry clears it.
  always_comb begin
    stateNext = state;
    ownerNext = owner;
    ptrNext   = ptr;
    cntNext   = cnt;
    byteNext  = byteReg;
    postWrite = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          ownerNext = pick;
          cntNext   = '0;
          stateNext = OWN;
        end
      end
      OWN: begin
        if (REQ_VALID[owner]) begin
          byteNext  = REQ_DATA[{owner, 3'b000} +: 8];
          stateNext = WRITE;
        end else if (cnt == CW'(LINE_TIMEOUT - 1)) begin
          ptrNext   = ownerInc;
          stateNext = IDLE;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      WRITE: begin
        if (GAP_CYCLES > 0) begin
          cntNext   = '0;
          stateNext = GAP;
        end else begin
          postWrite = 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) postWrite = 1'b1;
        else cntNext = cnt + CW'(1);
      end
      default: stateNext = IDLE;
    endcase
    // A newline ends the line: release and let the owner re-compete at lowest priority.
    if (postWrite) begin
      if (byteReg == ASCII_LF) begin
        ptrNext   = ownerInc;
        stateNext = IDLE;
      end else begin
        cntNext   = '0;
        stateNext = OWN;
      end
    end
  end

  always_comb begin
    REQ_READY       = '0;
    UART_WE         = 1'b0;
    UART_WRITE_ADDR = '0;
    UART_DATA_IN    = '0;
    UART_BE         = '0;
    if (state == OWN) REQ_READY[owner] = 1'b1;
    if (state == WRITE) begin
      UART_WE         = 1'b1;
      UART_WRITE_ADDR = DR_ADDR;
      UART_DATA_IN    = {24'h0, byteReg};
      UART_BE         = UART_BE_BYTE0;
    end
  end

  assign GRANT_ID = owner;
  assign BUSY     = (state != IDLE);

endmodule
